// File: rtl/uart_pkg.sv
// Shared UART link constants: opcodes, frame types/lengths, FSM states.
// Used by both the host link and the chip-side controller.
package uart_pkg;

  localparam logic [7:0] OP_SYNC     = 8'hBB;
  localparam logic [7:0] OP_MPR      = 8'h6D;
  localparam logic [7:0] OP_ADS_DATA = 8'hAA;
  localparam logic [7:0] OP_ADS_REG  = 8'h61;
  localparam logic [7:0] OP_RESET    = 8'h52;
  localparam logic [7:0] OP_START    = 8'h93;

  localparam logic [2:0] LEN_DATA = 3'd7;
  localparam logic [2:0] LEN_REG  = 3'd3;

  typedef enum logic [1:0] {
    FT_NONE     = 2'b00,
    FT_ADS_DATA = 2'b01,
    FT_ADS_REG  = 2'b10,
    FT_MPR_REG  = 2'b11
  } frame_type_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_SEND = 2'd1,
    T_WAIT = 2'd2
  } tx_state_e;

  typedef enum logic {
    R_IDLE    = 1'b0,
    R_COLLECT = 1'b1
  } rx_state_e;

  // Bytes to transmit for a command opcode; 0 means unsupported.
  function automatic logic [1:0] tx_len(input logic [7:0] op);
    logic [1:0] n;
    unique case (1'b1)
      (op == OP_RESET),
      (op == OP_START):   n = 2'd1;
      (op == OP_MPR),
      (op == OP_ADS_REG): n = 2'd2;
      default:            n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] rx_len(input logic [7:0] hdr);
    logic [2:0] n;
    unique case (1'b1)
      (hdr == OP_ADS_DATA): n = LEN_DATA;
      (hdr == OP_ADS_REG),
      (hdr == OP_MPR):      n = LEN_REG;
      default:              n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic frame_type_e rx_type(input logic [7:0] hdr);
    frame_type_e t;
    unique case (1'b1)
      (hdr == OP_ADS_DATA): t = FT_ADS_DATA;
      (hdr == OP_ADS_REG):  t = FT_ADS_REG;
      (hdr == OP_MPR):      t = FT_MPR_REG;
      default:              t = FT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// RX frame assembler: header decode, byte packing, inter-byte timeout.
// Frames are left-aligned in a 56-bit word, header in the top byte.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [7:0]  i_RX_BYTE,
  input  logic        i_RX_BYTE_VALID,
  output logic [55:0] o_FRAME,
  output logic [1:0]  o_FRAME_TYPE,
  output logic        o_FRAME_VALID,
  output logic        o_FRAME_ERR
);

  rx_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [55:0] buf_q, buf_d;
  frame_type_e ptype_q, ptype_d;
  logic [15:0] tmr_q, tmr_d;
  logic [55:0] frame_q, frame_d;
  logic [1:0]  otype_q, otype_d;
  logic        fvalid_q, fvalid_d;
  logic        ferr_q, ferr_d;
  logic [2:0]  hdr_len;
  logic [2:0]  cnt_inc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    buf_d    = buf_q;
    ptype_d  = ptype_q;
    tmr_d    = tmr_q;
    frame_d  = frame_q;
    otype_d  = otype_q;
    fvalid_d = 1'b0;
    ferr_d   = 1'b0;
    hdr_len  = rx_len(i_RX_BYTE);
    cnt_inc  = cnt_q + 3'd1;
    unique case (state_q)
      R_IDLE: begin
        if (i_RX_BYTE_VALID) begin
          if (hdr_len == 3'd0) begin
            ferr_d = 1'b1;
          end else begin
            buf_d   = {i_RX_BYTE, 48'h0};
            cnt_d   = 3'd1;
            len_d   = hdr_len;
            ptype_d = rx_type(i_RX_BYTE);
            tmr_d   = 16'd0;
            state_d = R_COLLECT;
          end
        end
      end
      R_COLLECT: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (i_RX_BYTE_VALID) begin
          tmr_d = 16'd0;
          for (int k = 1; k < 7; k++) begin
            if (cnt_q == 3'(k)) buf_d[55-8*k -: 8] = i_RX_BYTE;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            frame_d  = buf_d;
            otype_d  = ptype_q;
            fvalid_d = 1'b1;
            cnt_d    = 3'd0;
            state_d  = R_IDLE;
          end
        end else if (tmr_q == TIMEOUT_CYCLES - 16'd1) begin
          ferr_d  = 1'b1;
          cnt_d   = 3'd0;
          tmr_d   = 16'd0;
          state_d = R_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q  <= R_IDLE;
      cnt_q    <= 3'd0;
      len_q    <= 3'd0;
      buf_q    <= 56'h0;
      ptype_q  <= FT_NONE;
      tmr_q    <= 16'd0;
      frame_q  <= 56'h0;
      otype_q  <= 2'b00;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      ptype_q  <= ptype_d;
      tmr_q    <= tmr_d;
      frame_q  <= frame_d;
      otype_q  <= otype_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_FRAME       = frame_q;
  assign o_FRAME_TYPE  = otype_q;
  assign o_FRAME_VALID = fvalid_q;
  assign o_FRAME_ERR   = ferr_q;

endmodule

// File: rtl/uart_host_link.sv
// Host-side UART link: command-to-byte TX sequencing plus the RX
// frame assembler, running concurrently.
module uart_host_link
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [15:0] i_CMD,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  output logic [7:0]  o_TX_BYTE,
  output logic        o_TX_BYTE_VALID,
  input  logic        i_TX_BYTE_DONE,
  input  logic [7:0]  i_RX_BYTE,
  input  logic        i_RX_BYTE_VALID,
  output logic [55:0] o_FRAME,
  output logic [1:0]  o_FRAME_TYPE,
  output logic        o_FRAME_VALID,
  output logic        o_FRAME_ERR,
  output logic        o_CMD_ERR
);

  tx_state_e  tstate_q, tstate_d;
  logic       ready_q, ready_d;
  logic [7:0] txb_q, txb_d;
  logic       txv_q, txv_d;
  logic [7:0] addr_q, addr_d;
  logic       more_q, more_d;
  logic       cerr_q, cerr_d;
  logic [1:0] cmd_len;

  assign cmd_len = tx_len(i_CMD[15:8]);

  always_comb begin
    tstate_d = tstate_q;
    ready_d  = ready_q;
    txb_d    = txb_q;
    txv_d    = 1'b0;
    addr_d   = addr_q;
    more_d   = more_q;
    cerr_d   = 1'b0;
    unique case (tstate_q)
      T_IDLE: begin
        ready_d = 1'b1;
        if (i_CMD_VALID && ready_q) begin
          ready_d = 1'b0;
          if (cmd_len == 2'd0) begin
            cerr_d = 1'b1;
          end else begin
            txb_d    = i_CMD[15:8];
            txv_d    = 1'b1;
            addr_d   = i_CMD[7:0];
            more_d   = (cmd_len == 2'd2);
            tstate_d = T_SEND;
          end
        end
      end
      T_SEND: tstate_d = T_WAIT;
      T_WAIT: begin
        if (i_TX_BYTE_DONE) begin
          if (more_q) begin
            txb_d    = addr_q;
            txv_d    = 1'b1;
            more_d   = 1'b0;
            tstate_d = T_SEND;
          end else begin
            ready_d  = 1'b1;
            tstate_d = T_IDLE;
          end
        end
      end
      default: tstate_d = T_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      tstate_q <= T_IDLE;
      ready_q  <= 1'b0;
      txb_q    <= 8'h0;
      txv_q    <= 1'b0;
      addr_q   <= 8'h0;
      more_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      ready_q  <= ready_d;
      txb_q    <= txb_d;
      txv_q    <= txv_d;
      addr_q   <= addr_d;
      more_q   <= more_d;
      cerr_q   <= cerr_d;
    end
  end

  assign o_CMD_READY     = ready_q;
  assign o_TX_BYTE       = txb_q;
  assign o_TX_BYTE_VALID = txv_q;
  assign o_CMD_ERR       = cerr_q;

  uart_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .i_CLK          (i_CLK),
    .i_RSTN         (i_RSTN),
    .i_RX_BYTE      (i_RX_BYTE),
    .i_RX_BYTE_VALID(i_RX_BYTE_VALID),
    .o_FRAME        (o_FRAME),
    .o_FRAME_TYPE   (o_FRAME_TYPE),
    .o_FRAME_VALID  (o_FRAME_VALID),
    .o_FRAME_ERR    (o_FRAME_ERR)
  );

endmodule
